inst_rom_ctrl: RTL and testbench
================================

Name: inst_rom_ctrl

Overview:
- Instruction-memory responder for the core's fetch port: answers rom_ce/rom_addr requests with a registered 32-bit instruction word one cycle later.
- Includes a sequential program loader with a valid/ready word stream, so the memory is filled at run time rather than through $readmemh only.
- Sits outside the core at top level, driven by the PC stage's ce/addr and feeding the IF/ID register's instruction input.

Parameters:
- DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (default 1024 words).
- NOP_WORD, 32'h0000_0000, word returned whenever no valid fetch is served.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  fetch enable from the PC stage.
- addr  in  32  byte fetch address; word index is addr[DEPTH_LOG2+1:2].
- inst  out  32  registered instruction word.
- ld_start  in  1  single-cycle pulse; begins or restarts a load.
- ld_valid  in  1  ld_data carries a word.
- ld_data  in  32  program word to write.
- ld_last  in  1  qualifies the final word of a load, valid with ld_valid.
- ld_ready  out  1  loader accepts a word this cycle.
- ld_done  out  1  one-cycle pulse when a load completes.
- ld_count  out  DEPTH_LOG2+1  number of words written by the current or last load.
- busy  out  1  high while in LOAD.

Behaviour:
- States: IDLE, LOAD, RUN.
- Reset (asynchronous, any state): state=IDLE; inst=NOP_WORD; ld_ready=0; ld_done=0; ld_count=0; busy=0. Memory array contents are not reset.
- IDLE:
  - fetches return NOP_WORD.
  - ld_start -> LOAD next cycle with ld_count=0.
- LOAD:
  - busy=1 and ld_ready=1, both registered.
  - A beat is accepted only when ld_valid&ld_ready. It writes mem[ld_count[DEPTH_LOG2-1:0]] <= ld_data and increments ld_count.
  - Exit on an accepted beat with ld_last=1, or on the beat written at index DEPTH-1 (memory full; later words are not accepted).
  - Next cycle after exit: state=RUN, ld_ready=0, busy=0, ld_done=1 for exactly one cycle. ld_count holds its final value.
  - ld_start while in LOAD restarts the load: ld_count=0. A beat presented in the same cycle is dropped (restart wins).
- RUN:
  - ce=1 at edge N -> inst = mem[addr[DEPTH_LOG2+1:2]] after edge N. Latency is 1 cycle, fully pipelined, one word per cycle.
  - ce=0 -> inst = NOP_WORD next cycle.
  - Address bits above DEPTH_LOG2+1 are ignored, so fetches wrap modulo depth. addr[1:0] is ignored unless INST_ROM_ALIGN_CHECK_EN is defined.
  - Words never written read as undefined in simulation; the bench only checks written locations.
  - ld_start -> LOAD; all fetches return NOP_WORD from the next cycle on.
- No read/write collision is possible: fetches are not served in LOAD.
- ld_ready never depends combinationally on ld_valid.

Optional Feature:
- Macro: INST_ROM_ALIGN_CHECK_EN.
- Defined:
  - Adds output port misalign (1 bit, reset 0), registered alongside inst.
  - A RUN fetch with ce=1 and addr[1:0]!=0 returns inst=NOP_WORD and misalign=1 for that cycle.
  - misalign=0 otherwise.
- Undefined: no misalign port; addr[1:0] is ignored.

Test Plan:
- Reset then ce=1, addr=0 for 3 cycles -> inst stays 32'h0, ld_ready=0, busy=0.
- Load stream:
  - Stimulus: ld_start, then 4 beats 32'h3401_1100, 32'h3402_0020, 32'h3403_ff00, 32'h3404_ffff, with ld_last on the 4th.
  - Required response: ld_done pulses exactly once; ld_count=4; state RUN.
  - Then ce=1 with addr 0,4,8,12 on consecutive cycles -> inst equals those words, each one cycle after its address.
- Back-pressure/gaps: ld_valid toggled 1,0,1,0 across 6 beats -> only valid beats written; ld_count=6. Reading addr 20 returns the 6th word.
- Restart: ld_start asserted in the same cycle as beat 3 of a load -> beat 3 dropped; ld_count=0 next cycle. A subsequent 2-beat load overwrites words 0-1 only; ld_count=2.
- Full/wrap with DEPTH_LOG2=4:
  - Stream 20 beats without ld_last -> exactly 16 accepted; ld_done asserted after beat 16; ld_ready=0 afterwards.
  - Fetch addr=32'h40 -> returns word 0.
- With INST_ROM_ALIGN_CHECK_EN defined: RUN fetch at addr=32'h6 -> inst=0, misalign=1. Next fetch at addr=32'h4 -> correct word, misalign=0.
- Async reset asserted mid-LOAD, between clock edges -> outputs return to reset values immediately, without waiting for a clock edge. Fetches then return NOP until a new load completes.

Source files
------------

// File: rtl/inst_rom_ctrl.sv
// Instruction ROM responder with a run-time sequential program loader.
// Define INST_ROM_ALIGN_CHECK_EN to add the misalign output and reject unaligned fetches.
module inst_rom_ctrl #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic [31:0]           addr,
   output logic [31:0]           inst,
   input  logic                  ld_start,
   input  logic                  ld_valid,
   input  logic [31:0]           ld_data,
   input  logic                  ld_last,
   output logic                  ld_ready,
   output logic                  ld_done,
   output logic [DEPTH_LOG2:0]   ld_count,
   output logic                  busy
`ifdef INST_ROM_ALIGN_CHECK_EN
   ,
   output logic                  misalign
`endif
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0] CNT_FULL = DEPTH_LOG2'(DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StRun} state_t;

   state_t                state;
   logic [31:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_idx;
   logic [DEPTH_LOG2-1:0] rd_idx;
   logic                  accept;
   logic                  last_beat;
   logic                  fetch_ok;
   logic                  unused_addr;

   assign wr_idx      = ld_count[DEPTH_LOG2-1:0];
   assign rd_idx      = addr[DEPTH_LOG2+1:2];
   // ld_ready is only ever high in LOAD; a restart in the same cycle drops the beat
   assign accept      = ld_ready && ld_valid && !ld_start;
   assign last_beat   = ld_last || (ld_count == CNT_FULL);
   assign unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

`ifdef INST_ROM_ALIGN_CHECK_EN
   assign fetch_ok = (state == StRun) && ce && !ld_start && (addr[1:0] == 2'b00);
`else
   assign fetch_ok = (state == StRun) && ce && !ld_start;
`endif

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_idx] <= ld_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= StIdle;
         inst     <= NOP_WORD;
         ld_ready <= 1'b0;
         ld_done  <= 1'b0;
         ld_count <= '0;
         busy     <= 1'b0;
`ifdef INST_ROM_ALIGN_CHECK_EN
         misalign <= 1'b0;
`endif
      end else begin
         ld_done <= 1'b0;
         inst    <= fetch_ok ? mem[rd_idx] : NOP_WORD;
`ifdef INST_ROM_ALIGN_CHECK_EN
         misalign <= (state == StRun) && ce && !ld_start && (addr[1:0] != 2'b00);
`endif
         if (ld_start) begin
            state    <= StLoad;
            ld_ready <= 1'b1;
            busy     <= 1'b1;
            ld_count <= '0;
         end else if (accept) begin
            ld_count <= ld_count + CNT_ONE;
            if (last_beat) begin
               state    <= StRun;
               ld_ready <= 1'b0;
               busy     <= 1'b0;
               ld_done  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Scoreboard bench for inst_rom_ctrl (DEPTH_LOG2=4); fetch expectations are queued, a monitor checks them.
module tb_inst_rom_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic [31:0] addr;
   logic [31:0] inst;
   logic        ld_start;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        ld_last;
   logic        ld_ready;
   logic        ld_done;
   logic [4:0]  ld_count;
   logic        busy;
`ifdef INST_ROM_ALIGN_CHECK_EN
   logic        misalign;
`endif

   inst_rom_ctrl #(.DEPTH_LOG2(4), .NOP_WORD(NOP)) dut (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .addr     (addr),
      .inst     (inst),
      .ld_start (ld_start),
      .ld_valid (ld_valid),
      .ld_data  (ld_data),
      .ld_last  (ld_last),
      .ld_ready (ld_ready),
      .ld_done  (ld_done),
      .ld_count (ld_count),
      .busy     (busy)
`ifdef INST_ROM_ALIGN_CHECK_EN
      ,
      .misalign (misalign)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] inst;
      logic        mis;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic        chk_req = 1'b0;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          done_cnt = 0;
   int          done_base;

   // reference model of what the loader should have written
   logic [31:0] m_mem [16];
   int          m_count = 0;
   logic        m_loading = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: one expected entry per fetch cycle issued by the stimulus
   always @(posedge clk) begin
      if (chk_req) begin
         #1;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_underflow: got inst %h, expected a queued entry", inst);
         end else begin
            mon_e = exp_q.pop_front();
            check(mon_e.name, inst, mon_e.inst);
`ifdef INST_ROM_ALIGN_CHECK_EN
            check({mon_e.name, "_mis"}, {31'b0, misalign}, {31'b0, mon_e.mis});
`endif
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (ld_done === 1'b1) done_cnt++;
   end

   task automatic fetch(input string name, input logic c, input logic [31:0] a,
                        input logic [31:0] e, input logic mis);
      exp_t x;
      ce = c;
      addr = a;
      chk_req = 1'b1;
      x.name = name;
      x.inst = e;
      x.mis = mis;
      exp_q.push_back(x);
      @(negedge clk);
   endtask

   task automatic fetch_end();
      ce = 1'b0;
      chk_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic beat(input logic [31:0] d, input logic last, input logic v, input logic st);
      ld_valid = v;
      ld_data = d;
      ld_last = last;
      ld_start = st;
      if (st) begin
         m_loading = 1'b1;
         m_count = 0;
      end else if (v && m_loading) begin
         m_mem[m_count % 16] = d;
         m_count++;
         if (last || m_count == 16) m_loading = 1'b0;
      end
      @(negedge clk);
      ld_valid = 1'b0;
      ld_last = 1'b0;
      ld_start = 1'b0;
   endtask

   task automatic start_load();
      beat(32'h0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      ce = 1'b0;
      addr = '0;
      ld_start = 1'b0;
      ld_valid = 1'b0;
      ld_data = '0;
      ld_last = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      check("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_ld_count", {27'b0, ld_count}, 32'd0);
      check("rst_ld_done", {31'b0, ld_done}, 32'd0);
      for (int i = 0; i < 3; i++) fetch("idle_fetch", 1'b1, 32'h0, NOP, 1'b0);
      fetch_end();
      check("idle_ld_ready", {31'b0, ld_ready}, 32'd0);
      check("idle_busy", {31'b0, busy}, 32'd0);

      // basic 4-word load
      done_base = done_cnt;
      start_load();
      check("load_busy", {31'b0, busy}, 32'd1);
      check("load_ready", {31'b0, ld_ready}, 32'd1);
      check("load_count0", {27'b0, ld_count}, 32'd0);
      beat(32'h3401_1100, 1'b0, 1'b1, 1'b0);
      beat(32'h3402_0020, 1'b0, 1'b1, 1'b0);
      beat(32'h3403_ff00, 1'b0, 1'b1, 1'b0);
      beat(32'h3404_ffff, 1'b1, 1'b1, 1'b0);
      check("load_done", {31'b0, ld_done}, 32'd1);
      check("load_count", {27'b0, ld_count}, 32'd4);
      check("load_busy_off", {31'b0, busy}, 32'd0);
      check("load_ready_off", {31'b0, ld_ready}, 32'd0);
      @(negedge clk);
      check("load_done_pulse", {31'b0, ld_done}, 32'd0);
      fetch("run_w0", 1'b1, 32'h0, 32'h3401_1100, 1'b0);
      fetch("run_w1", 1'b1, 32'h4, 32'h3402_0020, 1'b0);
      fetch("run_w2", 1'b1, 32'h8, 32'h3403_ff00, 1'b0);
      fetch("run_w3", 1'b1, 32'hC, 32'h3404_ffff, 1'b0);
      fetch("run_ce0", 1'b0, 32'h4, NOP, 1'b0);
      fetch("run_w1b", 1'b1, 32'h4, 32'h3402_0020, 1'b0);
      fetch_end();
      check("load_done_once", done_cnt - done_base, 32'd1);

      // gaps: ld_valid 1,0,1,0 ... with junk data on idle cycles
      start_load();
      for (int i = 0; i < 6; i++) begin
         beat(32'hA000_0000 + i, (i == 5), 1'b1, 1'b0);
         if (i != 5) beat(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      end
      check("gap_count", {27'b0, ld_count}, 32'd6);
      fetch("gap_w5", 1'b1, 32'd20, 32'hA000_0005, 1'b0);
      fetch("gap_w1", 1'b1, 32'd4, 32'hA000_0001, 1'b0);
      fetch("gap_w0", 1'b1, 32'd0, m_mem[0], 1'b0);
      fetch_end();

      // restart in the same cycle as beat 3
      start_load();
      beat(32'hB000_0000, 1'b0, 1'b1, 1'b0);
      beat(32'hB000_0001, 1'b0, 1'b1, 1'b0);
      check("rs_count2", {27'b0, ld_count}, 32'd2);
      beat(32'hB000_0002, 1'b0, 1'b1, 1'b1);
      check("rs_count0", {27'b0, ld_count}, 32'd0);
      check("rs_busy", {31'b0, busy}, 32'd1);
      beat(32'hC000_0000, 1'b0, 1'b1, 1'b0);
      beat(32'hC000_0001, 1'b1, 1'b1, 1'b0);
      check("rs_final_count", {27'b0, ld_count}, 32'd2);
      fetch("rs_w0", 1'b1, 32'h0, 32'hC000_0000, 1'b0);
      fetch("rs_w1", 1'b1, 32'h4, 32'hC000_0001, 1'b0);
      fetch("rs_w2", 1'b1, 32'h8, 32'hA000_0002, 1'b0);
      fetch_end();

      // fill all 16 words, 4 extra beats must be ignored
      done_base = done_cnt;
      start_load();
      for (int i = 0; i < 20; i++) begin
         beat(32'hF000_0000 + i, 1'b0, 1'b1, 1'b0);
         if (i == 15) check("full_done", {31'b0, ld_done}, 32'd1);
         if (i == 16) check("full_done_pulse", {31'b0, ld_done}, 32'd0);
      end
      check("full_count", {27'b0, ld_count}, 32'd16);
      check("full_ready", {31'b0, ld_ready}, 32'd0);
      check("full_done_once", done_cnt - done_base, 32'd1);
      fetch("wrap_w0", 1'b1, 32'h40, 32'hF000_0000, 1'b0);
      fetch("full_w15", 1'b1, 32'h3C, 32'hF000_000F, 1'b0);
      fetch("wrap_w1", 1'b1, 32'h1_0044, 32'hF000_0001, 1'b0);
`ifdef INST_ROM_ALIGN_CHECK_EN
      fetch("align_bad", 1'b1, 32'h6, NOP, 1'b1);
      fetch("align_ok", 1'b1, 32'h4, 32'hF000_0001, 1'b0);
`endif
      fetch_end();

      // async reset between edges while loading
      start_load();
      beat(32'h5555_0000, 1'b0, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_inst", inst, NOP);
      check("arst_busy", {31'b0, busy}, 32'd0);
      check("arst_ready", {31'b0, ld_ready}, 32'd0);
      check("arst_count", {27'b0, ld_count}, 32'd0);
      check("arst_done", {31'b0, ld_done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      fetch("arst_nop0", 1'b1, 32'h0, NOP, 1'b0);
      fetch("arst_nop1", 1'b1, 32'h4, NOP, 1'b0);
      fetch_end();
      start_load();
      beat(32'h1234_5678, 1'b1, 1'b1, 1'b0);
      fetch("arst_reload", 1'b1, 32'h0, 32'h1234_5678, 1'b0);
      fetch_end();

      repeat (2) @(negedge clk);
      check("sb_drain", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
